// File: rtl/gpp_pkg.sv
// Shared types and sizing for the GPP instruction-fetch path.
package gpp_pkg;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MEM_DEPTH = 400;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    CAPT,
    ISSUE,
    DONE
  } state_t;
endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction memory sequencer: one-time program load, then single-issue
// fetch towards decode with valid/ready handshake and branch redirection.
module instr_fetch_ctrl
  import gpp_pkg::*;
#(
  parameter int unsigned ADDR_W    = gpp_pkg::ADDR_W,
  parameter int unsigned DATA_W    = gpp_pkg::DATA_W,
  parameter int unsigned MEM_DEPTH = gpp_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fin_file,
  input  logic [DATA_W-1:0] instr_in,
  output logic              read_file,
  output logic              read_memory,
  output logic [ADDR_W-1:0] pos,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] prog_len,
  output logic              done,
  output logic              err
);

  state_t state, state_nx;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   len_inc;
  logic [ADDR_W:0]   next_pc;
  logic              load_ovf;
  logic              br_bad;
  logic              handshake;

  // Extra bit on next_pc so that pc+1 wrapping past ADDR_W still ends the run.
  always_comb begin
    len_inc   = {1'b0, prog_len} + 1'b1;
    next_pc   = branch_valid ? {1'b0, branch_target} : ({1'b0, pc} + 1'b1);
    load_ovf  = read_file && (len_inc == (ADDR_W+1)'(MEM_DEPTH));
    br_bad    = branch_valid && (branch_target >= prog_len);
    handshake = (state == ISSUE) && !halt_req && instr_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD: begin
        if (fin_file)      state_nx = FETCH;
        else if (load_ovf) state_nx = DONE;
      end
      FETCH: state_nx = (halt_req || prog_len == '0) ? DONE : CAPT;
      CAPT:  state_nx = halt_req ? DONE : ISSUE;
      ISSUE: begin
        if (halt_req) state_nx = DONE;
        else if (instr_ready) begin
          if (br_bad || next_pc >= {1'b0, prog_len}) state_nx = DONE;
          else                                       state_nx = FETCH;
        end
      end
      DONE:  if (start) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    read_file   = (state == LOAD) && !fin_file;
    read_memory = (state == FETCH);
    pos         = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      prog_len    <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (state != DONE && state_nx == DONE) done <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            prog_len <= '0;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          if (read_file) prog_len <= len_inc[ADDR_W-1:0];
          if (fin_file)  pc <= '0;
          else if (load_ovf) err <= 1'b1;
        end
        FETCH: if (!halt_req && prog_len == '0) err <= 1'b1;
        CAPT: begin
          if (!halt_req) begin
            instr_out   <= instr_in;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (halt_req) instr_valid <= 1'b0;
          else if (handshake) begin
            instr_valid <= 1'b0;
            if (br_bad)                 err <= 1'b1;
            else if (state_nx == FETCH) pc  <= next_pc[ADDR_W-1:0];
          end
        end
        DONE: begin
          if (start) begin
            pc   <= '0;
            done <= 1'b0;
            err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural instruction memory.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        fin_file;
  logic [15:0] instr_in;
  logic        read_file;
  logic        read_memory;
  logic [8:0]  pos;
  logic [15:0] instr_out;
  logic [8:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_valid;
  logic [8:0]  branch_target;
  logic        halt_req;
  logic [8:0]  prog_len;
  logic        done;
  logic        err;

  instr_fetch_ctrl #(.ADDR_W(9), .DATA_W(16), .MEM_DEPTH(400)) dut (
    .clk(clk), .rst(rst), .start(start), .fin_file(fin_file),
    .instr_in(instr_in), .read_file(read_file), .read_memory(read_memory),
    .pos(pos), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .halt_req(halt_req), .prog_len(prog_len), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: counts load strobes, raises fin_file after load_n of them,
  // returns mem[pos] the cycle after a read strobe.
  logic [15:0] mem [0:511];
  logic [15:0] rd_q = '0;
  int rf_edges = 0;
  int rm_edges = 0;
  int rf_base  = 0;
  int load_n   = 5;
  int cyc      = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read_file)   rf_edges <= rf_edges + 1;
    if (read_memory) begin
      rm_edges <= rm_edges + 1;
      rd_q     <= mem[pos];
    end
  end

  assign fin_file = (rf_edges - rf_base) >= load_n;
  assign instr_in = rd_q;

  typedef struct { logic [8:0] pc; logic [15:0] data; } item_t;
  item_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int last_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin step(); n++; end
    chk("wait_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic wait_rm(input int budget);
    int n = 0;
    while (!read_memory && n < budget) begin step(); n++; end
    chk("wait_read_memory", {31'b0, read_memory}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    chk("wait_done", {31'b0, done}, 32'd1);
  endtask

  // Push the expected issue, then pop and compare when decode sees it valid.
  task automatic expect_item(input logic [8:0] pc, input logic [15:0] data);
    item_t e;
    sb_q.push_back('{pc: pc, data: data});
    wait_valid(20);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("instr_out", {16'b0, instr_out}, {16'b0, e.data});
      chk("instr_pc", {23'b0, instr_pc}, {23'b0, e.pc});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    mem[3] = 16'h4444; mem[4] = 16'h5555;
    rst = 1'b0; start = 1'b0; instr_ready = 1'b1;
    branch_valid = 1'b0; branch_target = '0; halt_req = 1'b0;

    // Reset state
    #12;
    chk("rst_read_file", {31'b0, read_file}, 32'd0);
    chk("rst_read_memory", {31'b0, read_memory}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_prog_len", {23'b0, prog_len}, 32'd0);
    chk("rst_pos", {23'b0, pos}, 32'd0);
    chk("rst_instr_out", {16'b0, instr_out}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Load of 5 words
    load_n = 5; rf_base = rf_edges;
    pulse_start();
    wait_rm(50);
    chk("load_edges", 32'(rf_edges - rf_base), 32'd5);
    chk("load_prog_len", {23'b0, prog_len}, 32'd5);
    chk("load_first_pos", {23'b0, pos}, 32'd0);

    // Sequential run, one instruction per 3 cycles
    for (int i = 0; i < 5; i++) begin
      expect_item(9'(i), mem[i]);
      if (last_cyc >= 0) chk("spacing", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
      step();
    end
    chk("seq_done", {31'b0, done}, 32'd1);
    chk("seq_err", {31'b0, err}, 32'd0);

    // Re-run with backpressure at pc 2, then branches
    pulse_start();
    chk("rerun_done_clr", {31'b0, done}, 32'd0);
    expect_item(9'd0, 16'h1111); step();
    expect_item(9'd1, 16'h2222); step();
    instr_ready = 1'b0;
    expect_item(9'd2, 16'h3333);
    begin
      int rm0;
      rm0 = rm_edges;
      for (int i = 0; i < 4; i++) begin
        step();
        chk("bp_valid", {31'b0, instr_valid}, 32'd1);
        chk("bp_instr_out", {16'b0, instr_out}, 32'h3333);
        chk("bp_read_memory", {31'b0, read_memory}, 32'd0);
      end
      chk("bp_no_reads", 32'(rm_edges - rm0), 32'd0);
    end
    instr_ready = 1'b1;
    step();
    expect_item(9'd3, 16'h4444);
    branch_valid = 1'b1; branch_target = 9'd1;
    step();
    branch_valid = 1'b0;
    chk("br_read_memory", {31'b0, read_memory}, 32'd1);
    chk("br_pos", {23'b0, pos}, 32'd1);
    expect_item(9'd1, 16'h2222);
    branch_valid = 1'b1; branch_target = 9'd7;
    step();
    branch_valid = 1'b0;
    chk("br_oob_err", {31'b0, err}, 32'd1);
    chk("br_oob_done", {31'b0, done}, 32'd1);
    chk("br_oob_valid", {31'b0, instr_valid}, 32'd0);

    // Halt wins over the handshake at pc 1
    pulse_start();
    chk("restart_done", {31'b0, done}, 32'd0);
    chk("restart_err", {31'b0, err}, 32'd0);
    expect_item(9'd0, 16'h1111); step();
    expect_item(9'd1, 16'h2222);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_done", {31'b0, done}, 32'd1);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_err", {31'b0, err}, 32'd0);
    chk("halt_pc_kept", {23'b0, pos}, 32'd1);
    pulse_start();
    chk("resume_rm", {31'b0, read_memory}, 32'd1);
    chk("resume_pos", {23'b0, pos}, 32'd0);
    chk("resume_done", {31'b0, done}, 32'd0);

    // Async reset while in ISSUE
    instr_ready = 1'b0;
    expect_item(9'd0, 16'h1111);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_instr_out", {16'b0, instr_out}, 32'd0);
    chk("arst_prog_len", {23'b0, prog_len}, 32'd0);
    chk("arst_rm", {31'b0, read_memory}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    step();
    rst = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("arst_idle_rf", {31'b0, read_file}, 32'd0);

    // Load overflow: end of file never arrives
    load_n = 1000; rf_base = rf_edges;
    pulse_start();
    wait_done(600);
    chk("ovf_edges", 32'(rf_edges - rf_base), 32'd400);
    chk("ovf_err", {31'b0, err}, 32'd1);
    chk("ovf_prog_len", {23'b0, prog_len}, 32'd400);
    step();
    chk("ovf_rf_off", {31'b0, read_file}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequencer for the instruction memory. Runs the one-time program load: it drives read_file until the memory reports end of file and counts the words loaded. It then fetches instructions one at a time by program counter, with a valid/ready handshake towards decode and branch redirection. Sits between the instruction memory and the decode stage of the GPP.

Parameters:
ADDR_W, 9, width of pc/pos and of the program-length counter
DATA_W, 16, instruction width
MEM_DEPTH, 400, instruction memory capacity in words

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  pulse: begin load (from IDLE) or re-run from pc 0 (from DONE)
fin_file  input  1  end-of-file flag from instruction memory
instr_in  input  DATA_W  instruction word returned by memory
read_file  output  1  memory load strobe
read_memory  output  1  memory read strobe
pos  output  ADDR_W  memory read address (= pc)
instr_out  output  DATA_W  instruction presented to decode
instr_pc  output  ADDR_W  address of instr_out
instr_valid  output  1  instr_out valid
instr_ready  input  1  decode accepts instr_out
branch_valid  input  1  sampled with the handshake: redirect
branch_target  input  ADDR_W  redirect address
halt_req  input  1  abort fetching
prog_len  output  ADDR_W  number of words loaded
done  output  1  fetch finished
err  output  1  error: load overflow or branch out of range

Behaviour:
- Reset (rst=0, async): state=IDLE. pc, prog_len, instr_out, instr_pc = 0. read_file, read_memory, instr_valid, done, err = 0.
- Memory contract: the memory samples a strobe on a rising edge. For reads, data is valid on instr_in in the cycle after the read_memory edge.
- IDLE: all strobes 0. start=1 -> LOAD; clears prog_len and err.
- LOAD:
  - read_file = (state==LOAD) && !fin_file, combinational, so no extra word is written after end of file.
  - prog_len increments on every edge where read_file=1.
  - fin_file=1 -> pc=0, go to FETCH.
  - prog_len reaching MEM_DEPTH with fin_file still 0 -> err=1, done=1, go to DONE.
- FETCH: read_memory=1, pos=pc. Next state CAPT.
- CAPT: read_memory=0. Register instr_out<=instr_in, instr_pc<=pc, instr_valid<=1. Next state ISSUE.
- ISSUE:
  - Hold instr_out and instr_valid stable until instr_ready=1.
  - On handshake, next_pc = branch_valid ? branch_target : pc+1, and instr_valid<=0.
  - branch_valid with branch_target >= prog_len -> err=1, go to DONE.
  - next_pc >= prog_len, including ADDR_W wrap -> go to DONE.
  - Otherwise pc<=next_pc, go to FETCH.
- Throughput: 3 cycles per instruction with instr_ready held at 1.
- halt_req=1 in FETCH, CAPT or ISSUE -> DONE on the next edge, instr_valid<=0. halt_req has priority over the handshake in the same cycle. halt_req is ignored in IDLE and LOAD.
- DONE:
  - done=1, all strobes 0, err held.
  - start=1 -> pc=0, done=0, err=0, go to FETCH. There is no reload; reload requires reset.
- start is ignored in LOAD, FETCH, CAPT and ISSUE.
- Reset mid-operation aborts immediately; memory contents are not the controller's concern.
- Empty program: fin_file arriving with prog_len=0 is impossible, because the first read_file edge always precedes the flag. If prog_len=0 in FETCH, go directly to DONE with err=1.

Decomposition:
- Shared package gpp_pkg: state enum (IDLE, LOAD, FETCH, CAPT, ISSUE, DONE), ADDR_W, DATA_W, MEM_DEPTH.
- No sub-module; a single FSM plus pc and length counters.

Test Plan:
- Load of 5 words: fin_file rises on the 5th read_file edge -> exactly 5 read_file edges, prog_len=5, FETCH starts with pos=0.
- Sequential run with instr_ready=1 over words 0x1111..0x5555 -> instr_out 0x1111..0x5555 with instr_pc 0..4, one every 3 cycles, then done=1 and err=0.
- Backpressure: instr_ready=0 for 4 cycles at pc=2 -> instr_out=0x3333 held stable, instr_valid held, no read_memory pulses.
- Branch at pc=3 to target 1 -> next read_memory has pos=1. Branch target 7 with prog_len=5 -> err=1, done=1.
- halt_req in the same cycle as the handshake at pc=1 -> DONE next edge, instr_valid=0. Then start -> fetch resumes at pos=0 with done=0.
- Async reset asserted during ISSUE -> all outputs 0 immediately, state IDLE. Overflow: fin_file held 0 -> stops after 400 read_file edges with err=1.
